// File: rtl/pf_mem_req_sched.sv
// pf_mem_req_sched: prefetch request scheduler with per-level (L2/L3) queues and outstanding caps.
// Latency: a request accepted at edge N can issue in cycle N+1; a response credit is usable in the cycle after it arrives.
// Backpressure: ready_o is low while either level FIFO is full, while flush_i is high, and while nreset is low.
//
// Ports (top):
//   clk, nreset                  clock, synchronous active-low reset
//   valid_i, mem_l2_v_i,
//   mem_l3_v_i, tag_i            decoded request and its level flags (L3 wins if both set)
//   flush_i                      drop every queued, not-yet-issued request
//   ready_o                      request accepted when valid_i & ready_o
//   lX_req_v_o/_tag_o/_ready_i   per-level issue handshake (FIFO head)
//   lX_rsp_v_i                   per-level completion pulse, returns one credit
//   busy_o                       anything queued or outstanding
//   err_o                        sticky: response seen with nothing outstanding

// pf_mem_req_fifo: tag FIFO with count, pointer wrap by power-of-two depth, synchronous flush.
// Latency: a push at edge N is visible at the head in cycle N+1; no same-cycle bypass.
// Backpressure: none internally; the caller only pushes when not full and pops when not empty.
module pf_mem_req_fifo #(
  parameter int DEPTH = 4,
  parameter int TW    = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [TW-1:0] dat_i,
  input  logic          pop_i,
  output logic [TW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [TW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    // Push and pop together leave the count alone while both pointers move.
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

// pf_mem_req_lvl: one memory level -- request FIFO, issue handshake and outstanding counter.
// Latency: head issues the cycle after it is pushed; a response frees a slot for the next cycle.
// Backpressure: issue stalls on empty FIFO, outstanding count at MAX_OUT, flush, or req_ready_i low.
module pf_mem_req_lvl #(
  parameter int DEPTH   = 4,
  parameter int TW      = 8,
  parameter int MAX_OUT = 3
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [TW-1:0] tag_i,
  output logic          full_o,
  output logic          req_v_o,
  output logic [TW-1:0] req_tag_o,
  input  logic          req_ready_i,
  input  logic          rsp_v_i,
  output logic          busy_o,
  output logic          rsp_err_o
);
  localparam logic [2:0] OUT_LIM = 3'(MAX_OUT);

  logic       empty;
  logic       xfer;
  logic [2:0] out_cnt_q, out_cnt_d;

  pf_mem_req_fifo #(.DEPTH(DEPTH), .TW(TW)) u_fifo (
    .clk     (clk),
    .nreset  (nreset),
    .flush_i (flush_i),
    .push_i  (push_i),
    .dat_i   (tag_i),
    .pop_i   (xfer),
    .head_o  (req_tag_o),
    .full_o  (full_o),
    .empty_o (empty)
  );

  // Uses only registered count, so a response never unlocks issue in its own cycle.
  assign req_v_o = nreset & ~empty & (out_cnt_q < OUT_LIM) & ~flush_i;
  assign xfer    = req_v_o & req_ready_i;

  always_comb begin
    out_cnt_d = out_cnt_q;
    rsp_err_o = 1'b0;
    case ({xfer, rsp_v_i})
      2'b10: out_cnt_d = out_cnt_q + 3'd1;
      2'b01: begin
        if (out_cnt_q != 3'd0) out_cnt_d = out_cnt_q - 3'd1;
        else                   rsp_err_o = 1'b1;
      end
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Flush leaves outstanding requests alone: they are already in the memory system.
  always_ff @(posedge clk) begin
    if (!nreset) out_cnt_q <= 3'd0;
    else         out_cnt_q <= out_cnt_d;
  end

  assign busy_o = nreset & (~empty | (out_cnt_q != 3'd0));
endmodule

// pf_mem_req_sched: routes decoded prefetches into L2/L3 level queues and tracks the sticky error.
// Latency: accept at edge N, earliest issue in cycle N+1 on the target level.
// Backpressure: single ready_o, low when either level is full, on flush, or in reset.
module pf_mem_req_sched #(
  parameter int DEPTH   = 4,
  parameter int TW      = 8,
  parameter int MAX_OUT = 3
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          valid_i,
  input  logic          mem_l2_v_i,
  input  logic          mem_l3_v_i,
  input  logic [TW-1:0] tag_i,
  input  logic          flush_i,
  output logic          ready_o,
  output logic          l2_req_v_o,
  output logic [TW-1:0] l2_req_tag_o,
  input  logic          l2_req_ready_i,
  input  logic          l2_rsp_v_i,
  output logic          l3_req_v_o,
  output logic [TW-1:0] l3_req_tag_o,
  input  logic          l3_req_ready_i,
  input  logic          l3_rsp_v_i,
  output logic          busy_o,
  output logic          err_o
);
  logic acc, push_l2, push_l3;
  logic l2_full, l3_full, l2_busy, l3_busy, l2_err, l3_err;
  logic err_q, err_d;

  // ready_o is kept independent of the level flags so decode can present it early.
  assign ready_o = nreset & ~l2_full & ~l3_full & ~flush_i;
  assign acc     = valid_i & ready_o;
  assign push_l3 = acc & mem_l3_v_i;
  // Neither flag set: accepted and dropped (L1 hit).
  assign push_l2 = acc & mem_l2_v_i & ~mem_l3_v_i;

  pf_mem_req_lvl #(.DEPTH(DEPTH), .TW(TW), .MAX_OUT(MAX_OUT)) u_l2 (
    .clk         (clk),
    .nreset      (nreset),
    .flush_i     (flush_i),
    .push_i      (push_l2),
    .tag_i       (tag_i),
    .full_o      (l2_full),
    .req_v_o     (l2_req_v_o),
    .req_tag_o   (l2_req_tag_o),
    .req_ready_i (l2_req_ready_i),
    .rsp_v_i     (l2_rsp_v_i),
    .busy_o      (l2_busy),
    .rsp_err_o   (l2_err)
  );

  pf_mem_req_lvl #(.DEPTH(DEPTH), .TW(TW), .MAX_OUT(MAX_OUT)) u_l3 (
    .clk         (clk),
    .nreset      (nreset),
    .flush_i     (flush_i),
    .push_i      (push_l3),
    .tag_i       (tag_i),
    .full_o      (l3_full),
    .req_v_o     (l3_req_v_o),
    .req_tag_o   (l3_req_tag_o),
    .req_ready_i (l3_req_ready_i),
    .rsp_v_i     (l3_rsp_v_i),
    .busy_o      (l3_busy),
    .rsp_err_o   (l3_err)
  );

  assign err_d = err_q | l2_err | l3_err;

  // err_o is not gated by nreset: it holds until the reset edge itself.
  always_ff @(posedge clk) begin
    if (!nreset) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o  = err_q;
  assign busy_o = l2_busy | l3_busy;
endmodule

// File: tb/tb_pf_mem_req_sched.sv
// tb_pf_mem_req_sched: directed vector table, corner-case sequences and random traffic against a queue model.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled on the falling edge.
// Backpressure: the model decides acceptance from its own queue occupancy and the flush input.
module tb_pf_mem_req_sched;
  localparam int DEPTH = 4, TW = 8, MAX_OUT = 3;

  logic          clk = 1'b0;
  logic          nreset, valid_i, mem_l2_v_i, mem_l3_v_i, flush_i;
  logic [TW-1:0] tag_i;
  logic          ready_o, l2_req_v_o, l2_req_ready_i, l2_rsp_v_i;
  logic          l3_req_v_o, l3_req_ready_i, l3_rsp_v_i, busy_o, err_o;
  logic [TW-1:0] l2_req_tag_o, l3_req_tag_o;

  always #5 clk = ~clk;

  pf_mem_req_sched #(.DEPTH(DEPTH), .TW(TW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .mem_l2_v_i(mem_l2_v_i),
    .mem_l3_v_i(mem_l3_v_i), .tag_i(tag_i), .flush_i(flush_i), .ready_o(ready_o),
    .l2_req_v_o(l2_req_v_o), .l2_req_tag_o(l2_req_tag_o), .l2_req_ready_i(l2_req_ready_i),
    .l2_rsp_v_i(l2_rsp_v_i), .l3_req_v_o(l3_req_v_o), .l3_req_tag_o(l3_req_tag_o),
    .l3_req_ready_i(l3_req_ready_i), .l3_rsp_v_i(l3_rsp_v_i), .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct packed {
    logic rn, vl, a2, a3;
    logic [7:0] tag;
    logic fl, r2, s2, r3, s3;
  } in_t;
  typedef struct packed {
    logic rdy, v2;
    logic [7:0] t2;
    logic v3;
    logic [7:0] t3;
    logic busy, err;
  } out_t;
  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: plain per-level queues, outstanding integers, sticky error bit.
  logic [7:0] q2[$];
  logic [7:0] q3[$];
  int o2, o3;
  bit merr;

  function automatic in_t mk(bit rn, bit vl, bit a2, bit a3, logic [7:0] t,
                             bit fl, bit r2, bit s2, bit r3, bit s3);
    in_t v;
    v.rn = rn; v.vl = vl; v.a2 = a2; v.a3 = a3; v.tag = t;
    v.fl = fl; v.r2 = r2; v.s2 = s2; v.r3 = r3; v.s3 = s3;
    return v;
  endfunction

  function automatic out_t eo(bit rdy, bit v2, logic [7:0] t2, bit v3, logic [7:0] t3, bit busy, bit err);
    out_t o;
    o.rdy = rdy; o.v2 = v2; o.t2 = t2; o.v3 = v3; o.t3 = t3; o.busy = busy; o.err = err;
    return o;
  endfunction

  function automatic bit m_ready(in_t v);
    return v.rn && (q2.size() < DEPTH) && (q3.size() < DEPTH) && !v.fl;
  endfunction
  function automatic bit m_v2(in_t v);
    return v.rn && (q2.size() > 0) && (o2 < MAX_OUT) && !v.fl;
  endfunction
  function automatic bit m_v3(in_t v);
    return v.rn && (q3.size() > 0) && (o3 < MAX_OUT) && !v.fl;
  endfunction
  function automatic bit m_busy(in_t v);
    return v.rn && (q2.size() > 0 || q3.size() > 0 || o2 != 0 || o3 != 0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(in_t v);
    nreset = v.rn; valid_i = v.vl; mem_l2_v_i = v.a2; mem_l3_v_i = v.a3; tag_i = v.tag;
    flush_i = v.fl; l2_req_ready_i = v.r2; l2_rsp_v_i = v.s2; l3_req_ready_i = v.r3; l3_rsp_v_i = v.s3;
  endtask

  task automatic check_model(in_t v);
    chk("m_ready", ready_o, m_ready(v));
    chk("m_l2_v", l2_req_v_o, m_v2(v));
    chk("m_l3_v", l3_req_v_o, m_v3(v));
    if (m_v2(v)) chk("m_l2_tag", l2_req_tag_o, q2[0]);
    if (m_v3(v)) chk("m_l3_tag", l3_req_tag_o, q3[0]);
    chk("m_busy", busy_o, m_busy(v));
    chk("m_err", err_o, merr);
  endtask

  task automatic model_update(in_t v);
    bit acc, x2, x3;
    acc = v.vl && m_ready(v);
    x2  = m_v2(v) && v.r2;
    x3  = m_v3(v) && v.r3;
    if (!v.rn) begin
      q2.delete(); q3.delete(); o2 = 0; o3 = 0; merr = 0;
      return;
    end
    if (v.fl) begin q2.delete(); q3.delete(); end
    if (x2) void'(q2.pop_front());
    if (x3) void'(q3.pop_front());
    if (acc && v.a3)      q3.push_back(v.tag);
    else if (acc && v.a2) q2.push_back(v.tag);
    if (x2 && !v.s2) o2++;
    else if (!x2 && v.s2) begin if (o2 == 0) merr = 1; else o2--; end
    if (x3 && !v.s3) o3++;
    else if (!x3 && v.s3) begin if (o3 == 0) merr = 1; else o3--; end
  endtask

  task automatic begin_cyc(in_t v);
    apply(v);
    @(negedge clk);
    check_model(v);
  endtask

  task automatic end_cyc(in_t v);
    @(posedge clk);
    model_update(v);
    #1;
  endtask

  task automatic step(in_t v);
    begin_cyc(v);
    end_cyc(v);
  endtask

  // Returns every credit; bounded so a stuck DUT still reaches the summary.
  task automatic drain(string name);
    in_t v;
    for (int k = 0; k < 60; k++) begin
      v = mk(1, 0, 0, 0, 8'h00, 0, 1, o2 > 0, 1, o3 > 0);
      step(v);
    end
    begin_cyc(mk(1, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0));
    chk(name, busy_o, 0);
    end_cyc(mk(1, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0));
  endtask

  vec_t tbl[$];
  in_t  idle, v;
  int   nx;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk(1, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0);
    // Routing: 11->L2, 22->L3, 33 dropped, 44 (both flags) -> L3.
    tbl.push_back(vec_t'{mk(0,0,0,0,8'h00,0,1,0,1,0), eo(0,0,8'h00,0,8'h00,0,0)});
    tbl.push_back(vec_t'{mk(1,1,1,0,8'h11,0,1,0,1,0), eo(1,0,8'h00,0,8'h00,0,0)});
    tbl.push_back(vec_t'{mk(1,1,0,1,8'h22,0,1,0,1,0), eo(1,1,8'h11,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,1,0,0,8'h33,0,1,0,1,0), eo(1,0,8'h00,1,8'h22,1,0)});
    tbl.push_back(vec_t'{mk(1,1,1,1,8'h44,0,1,0,1,0), eo(1,0,8'h00,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,0,0,0,8'h00,0,1,0,1,0), eo(1,0,8'h00,1,8'h44,1,0)});
    tbl.push_back(vec_t'{mk(1,0,0,0,8'h00,0,1,1,1,1), eo(1,0,8'h00,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,0,0,0,8'h00,0,1,0,1,1), eo(1,0,8'h00,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,0,0,0,8'h00,0,1,0,1,0), eo(1,0,8'h00,0,8'h00,0,0)});
    // Full: five L2 requests with L2 stalled, fifth held by the source, then in-order drain.
    tbl.push_back(vec_t'{mk(1,1,1,0,8'hA1,0,0,0,1,0), eo(1,0,8'h00,0,8'h00,0,0)});
    tbl.push_back(vec_t'{mk(1,1,1,0,8'hA2,0,0,0,1,0), eo(1,1,8'hA1,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,1,1,0,8'hA3,0,0,0,1,0), eo(1,1,8'hA1,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,1,1,0,8'hA4,0,0,0,1,0), eo(1,1,8'hA1,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,1,1,0,8'hA5,0,0,0,1,0), eo(0,1,8'hA1,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,1,1,0,8'hA5,0,1,0,1,0), eo(0,1,8'hA1,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,1,1,0,8'hA5,0,1,0,1,0), eo(1,1,8'hA2,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,0,0,0,8'h00,0,1,0,1,0), eo(1,1,8'hA3,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,0,0,0,8'h00,0,1,1,1,0), eo(1,0,8'h00,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,0,0,0,8'h00,0,1,0,1,0), eo(1,1,8'hA4,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,0,0,0,8'h00,0,1,1,1,0), eo(1,0,8'h00,0,8'h00,1,0)});
    // Transfer and response together at out_cnt 2: stays 2, so two more responses empty it.
    tbl.push_back(vec_t'{mk(1,0,0,0,8'h00,0,1,1,1,0), eo(1,1,8'hA5,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,0,0,0,8'h00,0,1,1,1,0), eo(1,0,8'h00,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,0,0,0,8'h00,0,1,1,1,0), eo(1,0,8'h00,0,8'h00,1,0)});
    tbl.push_back(vec_t'{mk(1,0,0,0,8'h00,0,1,0,1,0), eo(1,0,8'h00,0,8'h00,0,0)});

    apply(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0));
    model_update(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0));
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      apply(tbl[k].i);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", k), ready_o, tbl[k].o.rdy);
      chk($sformatf("vec%0d_l2v", k), l2_req_v_o, tbl[k].o.v2);
      chk($sformatf("vec%0d_l3v", k), l3_req_v_o, tbl[k].o.v3);
      if (tbl[k].o.v2) chk($sformatf("vec%0d_l2tag", k), l2_req_tag_o, tbl[k].o.t2);
      if (tbl[k].o.v3) chk($sformatf("vec%0d_l3tag", k), l3_req_tag_o, tbl[k].o.t3);
      chk($sformatf("vec%0d_busy", k), busy_o, tbl[k].o.busy);
      chk($sformatf("vec%0d_err", k), err_o, tbl[k].o.err);
      check_model(tbl[k].i);
      end_cyc(tbl[k].i);
    end

    // Outstanding cap on L3: three transfers, then one credit buys exactly one more, a cycle later.
    nx = 0;
    for (int i = 0; i < 5; i++) begin
      v = mk(1, 1, 0, 1, 8'(8'hC1 + i), 0, 1, 0, 1, 0);
      begin_cyc(v);
      if (l3_req_v_o) nx++;
      end_cyc(v);
    end
    repeat (2) begin
      begin_cyc(idle);
      if (l3_req_v_o) nx++;
      end_cyc(idle);
    end
    chk("cap_xfers", nx, 3);
    v = mk(1, 0, 0, 0, 8'h00, 0, 1, 0, 1, 1);
    begin_cyc(v); chk("cap_no_bypass", l3_req_v_o, 0); end_cyc(v);
    begin_cyc(idle); chk("cap_credit_v", l3_req_v_o, 1); chk("cap_credit_tag", l3_req_tag_o, 8'hC4); end_cyc(idle);
    begin_cyc(idle); chk("cap_after", l3_req_v_o, 0); end_cyc(idle);
    drain("cap_drain_busy");

    // Push and pop together at L2 count 2: exactly two more pushes fill it.
    step(mk(1, 1, 1, 0, 8'hB1, 0, 0, 0, 1, 0));
    step(mk(1, 1, 1, 0, 8'hB2, 0, 0, 0, 1, 0));
    v = mk(1, 1, 1, 0, 8'hB3, 0, 1, 0, 1, 0);
    begin_cyc(v); chk("pp_pop_v", l2_req_v_o, 1); chk("pp_push_rdy", ready_o, 1); end_cyc(v);
    v = mk(1, 1, 1, 0, 8'hB4, 0, 0, 0, 1, 0);
    begin_cyc(v); chk("pp_rdy3", ready_o, 1); end_cyc(v);
    v = mk(1, 1, 1, 0, 8'hB5, 0, 0, 0, 1, 0);
    begin_cyc(v); chk("pp_rdy4", ready_o, 1); end_cyc(v);
    v = mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0);
    begin_cyc(v); chk("pp_full", ready_o, 0); chk("pp_head", l2_req_tag_o, 8'hB2); end_cyc(v);
    drain("pp_drain_busy");

    // Flush with 3 queued and 2 outstanding on L2.
    step(mk(1, 1, 1, 0, 8'hD1, 0, 1, 0, 1, 0));
    step(mk(1, 1, 1, 0, 8'hD2, 0, 1, 0, 1, 0));
    step(mk(1, 1, 1, 0, 8'hD3, 0, 1, 0, 1, 0));
    step(mk(1, 1, 1, 0, 8'hD4, 0, 0, 0, 1, 0));
    step(mk(1, 1, 1, 0, 8'hD5, 0, 0, 0, 1, 0));
    v = mk(1, 1, 1, 0, 8'hD6, 1, 1, 0, 1, 0);
    begin_cyc(v); chk("fl_no_accept", ready_o, 0); chk("fl_no_issue", l2_req_v_o, 0); end_cyc(v);
    begin_cyc(idle); chk("fl_empty_v", l2_req_v_o, 0); chk("fl_ready", ready_o, 1); chk("fl_busy0", busy_o, 1); end_cyc(idle);
    v = mk(1, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0);
    begin_cyc(v); chk("fl_busy1", busy_o, 1); end_cyc(v);
    begin_cyc(v); chk("fl_busy2", busy_o, 1); end_cyc(v);
    begin_cyc(idle); chk("fl_idle", busy_o, 0); chk("fl_err", err_o, 0); end_cyc(idle);

    // Sticky error, cleared only by the reset edge.
    v = mk(1, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0);
    begin_cyc(v); chk("err_pre", err_o, 0); end_cyc(v);
    begin_cyc(idle); chk("err_set", err_o, 1); end_cyc(idle);
    repeat (3) step(idle);
    v = mk(0, 1, 1, 0, 8'h55, 0, 1, 0, 1, 0);
    begin_cyc(v); chk("err_hold_rst", err_o, 1); chk("rst_ready", ready_o, 0); end_cyc(v);
    begin_cyc(idle); chk("err_clr", err_o, 0); chk("rst_rel_ready", ready_o, 1); end_cyc(idle);

    // Reset mid-operation: a stale response afterwards is an error.
    step(mk(1, 1, 0, 1, 8'hE1, 0, 1, 0, 1, 0));
    step(idle);
    v = mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0);
    begin_cyc(v); chk("rst_busy_low", busy_o, 0); chk("rst_l3v_low", l3_req_v_o, 0); end_cyc(v);
    v = mk(1, 0, 0, 0, 8'h00, 0, 1, 0, 1, 1);
    begin_cyc(v); chk("stale_busy", busy_o, 0); end_cyc(v);
    begin_cyc(idle); chk("stale_err", err_o, 1); end_cyc(idle);
    step(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0));

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      v.rn  = ($urandom_range(0, 99) != 0);
      v.vl  = ($urandom_range(0, 99) < 65);
      v.a2  = 1'($urandom_range(0, 1));
      v.a3  = ($urandom_range(0, 2) == 0);
      v.tag = 8'($urandom);
      v.fl  = ($urandom_range(0, 99) < 3);
      v.r2  = ($urandom_range(0, 99) < 70);
      v.r3  = ($urandom_range(0, 99) < 60);
      v.s2  = (o2 > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 299) == 0);
      v.s3  = (o3 > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 299) == 0);
      step(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pf_mem_req_sched.md
# pf_mem_req_sched

Prefetch memory-request scheduler, placed directly after the prefetch decode stage. It takes each decoded request, already classified as L2, L3 or no-request (L1), and buffers it in a per-level FIFO. It issues requests to the L2 and L3 ports over valid/ready handshakes and caps outstanding requests per level. Back-pressure to decode is a single `ready_o`.

## Interface
- `DEPTH`, 4: entries per level FIFO; must be a power of two and ≥2.
- `TW`, 8: request tag width.
- `MAX_OUT`, 3: maximum outstanding requests per level; range 1..7.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `nreset`  in  1  reset, synchronous, active-low.
- `valid_i`  in  1  decoded request valid.
- `mem_l2_v_i`  in  1  request targets L2.
- `mem_l3_v_i`  in  1  request targets L3.
- `tag_i`  in  TW  request tag.
- `flush_i`  in  1  discard all queued, not-yet-issued requests.
- `ready_o`  out  1  scheduler can accept a request this cycle.
- `l2_req_v_o`  out  1  L2 request valid.
- `l2_req_tag_o`  out  TW  L2 request tag (FIFO head).
- `l2_req_ready_i`  in  1  L2 accepts request.
- `l2_rsp_v_i`  in  1  one L2 request completed.
- `l3_req_v_o`, `l3_req_tag_o`, `l3_req_ready_i`, `l3_rsp_v_i`: same as the L2 ports, for L3.
- `busy_o`  out  1  any queue non-empty or any request outstanding.
- `err_o`  out  1  sticky: response received with zero outstanding.

## Operation
- Accept: `valid_i & ready_o`.
  - `ready_o = ~l2_full & ~l3_full & ~flush_i`. It depends only on registered state and `flush_i`, never on `valid_i` or the level flags.
- Routing of an accepted request:
  - `mem_l3_v_i` = 1: push into the L3 FIFO. L3 has priority if both flags are set.
  - Only `mem_l2_v_i` = 1: push into the L2 FIFO.
  - Neither flag set: the request is accepted and dropped (L1 hit). No state changes.
- FIFO per level:
  - Write pointer, read pointer and a count of width log2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
  - Full when count == DEPTH; empty when count == 0.
- Issue, per level:
  - `req_v_o = ~empty & (out_cnt < MAX_OUT) & ~flush_i`.
  - `req_tag_o` = the tag at the FIFO head.
  - A transfer occurs when `req_v_o & req_ready_i`. It pops the FIFO and increments `out_cnt`.
  - Once `req_v_o` is high, head and tag stay stable until the transfer or a flush.
- Outstanding counter `out_cnt`, per level, width 3:
  - +1 on transfer, −1 on `rsp_v_i`.
  - Transfer and response in the same cycle leave it unchanged.
  - `rsp_v_i` while `out_cnt` == 0 and no transfer that cycle: the counter stays 0 and `err_o` sets.
- Same-cycle push and pop on one FIFO: count unchanged, both pointers advance.
- Flush (`flush_i` = 1):
  - Both FIFO counts and pointers return to 0 on the next edge.
  - No accept and no issue occur in the flush cycle.
  - `out_cnt` is unaffected; responses keep decrementing it.
- `busy_o = l2_nonempty | l3_nonempty | (l2_out_cnt != 0) | (l3_out_cnt != 0)`.
- The L2 and L3 levels are fully independent. There is no ordering between them; each level is in order (FIFO).

## Timing
- Reset (`nreset` = 0 at an edge):
  - FIFOs empty, `out_cnt` = 0, `err_o` = 0.
  - While `nreset` is low, `ready_o` = 0, `l2_req_v_o` = `l3_req_v_o` = 0 and `busy_o` = 0.
  - First cycle after release: `ready_o` = 1.
- Reset mid-operation: queued and outstanding state is discarded. Any later responses for those requests set `err_o`.
- Latency: a request accepted at edge N can present `req_v_o` = 1 in cycle N+1. There is no same-cycle bypass.
- Throughput: one accept per cycle and one issue per level per cycle.
- `ready_o` drops in the cycle after the edge at which either FIFO reaches DEPTH. It rises the cycle after a pop leaves the FIFO not full.
- Credit: a response at edge N lets the same level issue in cycle N+1. There is no same-cycle response-to-issue bypass.
- `err_o` asserts the cycle after the offending response and holds until reset.

## Test plan
- Reset then route:
  - Stimulus: tags 0x11 (L2), 0x22 (L3), 0x33 (neither), 0x44 (both), with both ready inputs held at 1.
  - Required: L2 issues 0x11; L3 issues 0x22 then 0x44; 0x33 is never issued. Each issue is exactly 1 cycle after its accept.
- Full/back-pressure:
  - Stimulus: `l2_req_ready_i` = 0, then 5 consecutive L2 requests with DEPTH = 4.
  - Required: 4 accepted; `ready_o` = 0 from the 5th cycle; the 5th tag is held by the source. Raising ready drains tags in accept order.
- Outstanding cap:
  - Stimulus: MAX_OUT = 3, 5 L3 requests, no responses.
  - Required: exactly 3 transfers, then `l3_req_v_o` = 0. One `l3_rsp_v_i` pulse allows exactly 1 more transfer, in the following cycle.
- Simultaneous events:
  - Stimulus: same-cycle push+pop with L2 count 2; same-cycle transfer+response with `out_cnt` 2.
  - Required: count stays 2 and `out_cnt` stays 2.
- Flush:
  - Stimulus: 3 requests queued in L2, 2 outstanding; pulse `flush_i`.
  - Required: no accept or issue in the flush cycle; both FIFOs empty next cycle; `busy_o` stays 1 until 2 responses arrive, then 0.
- Error/reset:
  - Stimulus: `l2_rsp_v_i` pulse with 0 outstanding.
  - Required: `err_o` = 1 next cycle and sticky. It clears only at the edge where `nreset` = 0.
